// File: rtl/idwt_stage.sv
// idwt_stage: one level of Haar inverse-DWT synthesis; each (A, D) pair becomes two samples, A+D then A-D.
module idwt_stage #(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 0,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] approx_in,
  input  logic signed [DATA_W-1:0] detail_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] filter_out,
  output logic                     out_odd,
  output logic                     sat_flag
);
  typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;
  localparam logic [DATA_W-1:0] MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
  state_t state, state_nx;
  logic in_xfer, out_xfer, sum_ovf, dif_ovf;
  logic signed [DATA_W:0] sum_w, dif_w, sum_sh, dif_sh;
  logic [DATA_W-1:0] sum_r, dif_r, sum_q, dif_q;
  // Results are formed one bit wider so the sum/difference never overflows before the shift.
  assign sum_w = approx_in + detail_in;
  assign dif_w = approx_in - detail_in;
  assign sum_sh = sum_w >>> SHIFT;
  assign dif_sh = dif_w >>> SHIFT;
  assign sum_ovf = sum_sh[DATA_W] != sum_sh[DATA_W-1];
  assign dif_ovf = dif_sh[DATA_W] != dif_sh[DATA_W-1];
  assign sum_r = (sum_ovf && SAT != 0) ? (sum_sh[DATA_W] ? MIN : MAX) : sum_sh[DATA_W-1:0];
  assign dif_r = (dif_ovf && SAT != 0) ? (dif_sh[DATA_W] ? MIN : MAX) : dif_sh[DATA_W-1:0];
  assign in_xfer = in_valid & in_ready & clk_enable;
  assign out_xfer = out_valid & out_ready & clk_enable;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else if (clk_enable) state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (in_xfer ? EVEN : IDLE) :
               state == EVEN ? (out_xfer ? ODD : EVEN) :
               out_xfer ? (in_xfer ? EVEN : IDLE) : state;
  always_comb begin
    in_ready = !reset && clk_enable && (state == IDLE || (state == ODD && out_ready));
    out_valid = state != IDLE;
    out_odd = state == ODD;
    filter_out = state == EVEN ? sum_q : state == ODD ? dif_q : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sum_q <= '0;
      dif_q <= '0;
      sat_flag <= 1'b0;
    end else if (in_xfer) begin
      sum_q <= sum_r;
      dif_q <= dif_r;
      sat_flag <= sat_flag | sum_ovf | dif_ovf;
    end
endmodule

// File: tb/tb_idwt_stage.sv
// tb_idwt_stage: directed checks of the Haar synthesis stage, saturating and wrapping variants side by side.
module tb_idwt_stage;
  logic clk, reset, clk_enable, in_valid, out_ready;
  logic signed [15:0] a, d;
  logic in_ready, out_valid, out_odd, sat_flag;
  logic signed [15:0] filter_out;
  logic w_in_ready, w_out_valid, w_out_odd, w_sat_flag;
  logic signed [15:0] w_filter_out;
  int total = 0;
  int bad = 0;

  idwt_stage #(.DATA_W(16), .SHIFT(0), .SAT(1)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_valid(in_valid), .in_ready(in_ready),
    .approx_in(a), .detail_in(d), .out_valid(out_valid), .out_ready(out_ready),
    .filter_out(filter_out), .out_odd(out_odd), .sat_flag(sat_flag));

  idwt_stage #(.DATA_W(16), .SHIFT(0), .SAT(0)) dut_w (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_valid(in_valid), .in_ready(w_in_ready),
    .approx_in(a), .detail_in(d), .out_valid(w_out_valid), .out_ready(out_ready),
    .filter_out(w_filter_out), .out_odd(w_out_odd), .sat_flag(w_sat_flag));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int v, input int odd, input int rdy);
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " data"}, filter_out, v);
    chk({tag, " odd"}, out_odd, odd);
    chk({tag, " in_ready"}, in_ready, rdy);
  endtask

  initial begin
    reset = 1; clk_enable = 1; in_valid = 0; out_ready = 1; a = 0; d = 0;
    step;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst filter_out", filter_out, 0);
    chk("rst out_odd", out_odd, 0);
    chk("rst sat_flag", sat_flag, 0);
    reset = 0;
    #1;
    chk("post-rst in_ready", in_ready, 1);
    // single pair 100, 30
    in_valid = 1; a = 100; d = 30;
    step;
    in_valid = 0;
    chk_out("p1 even", 130, 0, 0);
    step;
    chk_out("p1 odd", 70, 1, 1);
    step;
    chk("p1 idle valid", out_valid, 0);
    chk("p1 idle in_ready", in_ready, 1);
    chk("p1 sat_flag", sat_flag, 0);
    // back-to-back pairs without a bubble
    in_valid = 1; a = 10; d = 2;
    step;
    a = -8; d = 3;
    chk_out("b2b e0", 12, 0, 0);
    step;
    chk_out("b2b o0", 8, 1, 1);
    step;
    in_valid = 0;
    chk_out("b2b e1", -5, 0, 0);
    step;
    chk_out("b2b o1", -11, 1, 1);
    step;
    chk("b2b idle", out_valid, 0);
    // backpressure in EVEN
    in_valid = 1; a = 100; d = 30;
    step;
    in_valid = 0; out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk_out("bp hold", 130, 0, 0);
    end
    out_ready = 1;
    step;
    chk_out("bp odd", 70, 1, 1);
    step;
    chk("bp idle", out_valid, 0);
    // clk_enable dropped while in ODD, and while IDLE
    clk_enable = 0;
    #1;
    chk("ce idle in_ready", in_ready, 0);
    clk_enable = 1; in_valid = 1; a = 100; d = 30;
    step;
    in_valid = 0;
    step;
    clk_enable = 0;
    #1;
    chk_out("ce stop", 70, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk_out("ce hold", 70, 1, 0);
    end
    clk_enable = 1;
    #1;
    chk_out("ce resume", 70, 1, 1);
    step;
    chk("ce idle", out_valid, 0);
    // saturation versus wrap
    in_valid = 1; a = 32000; d = 1000;
    step;
    in_valid = 0;
    chk_out("sat even", 32767, 0, 0);
    chk("wrap even", w_filter_out, -32536);
    chk("sat flag", sat_flag, 1);
    chk("wrap flag", w_sat_flag, 1);
    step;
    chk_out("sat odd", 31000, 1, 1);
    chk("wrap odd", w_filter_out, 31000);
    step;
    chk("sat flag sticky", sat_flag, 1);
    // reset while in ODD drops the held odd sample
    in_valid = 1; a = 100; d = 30;
    step;
    in_valid = 0;
    step;
    chk_out("rs odd", 70, 1, 1);
    reset = 1;
    step;
    reset = 0;
    #1;
    chk("rs valid", out_valid, 0);
    chk("rs filter_out", filter_out, 0);
    chk("rs sat_flag", sat_flag, 0);
    chk("rs wrap sat_flag", w_sat_flag, 0);
    chk("rs in_ready", in_ready, 1);
    step;
    chk("rs no odd", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
